axi_wr_decoder: RTL and testbench
=================================

Name: axi_wr_decoder

Overview: Single-clock AXI write-channel router that sits directly upstream of the watchdog and peripheral AXI slave wrappers. It takes one master-side write port and decodes AWADDR[31:16] to one of two slave ports: S0 is a general peripheral and S1 is the WDT wrapper. Unmapped addresses terminate in an internal default slave that returns DECERR. It supports one outstanding write transaction at a time.

Parameters:
S0_HI, 16'h0001, AWADDR[31:16] value that selects slave port S0
S1_HI, 16'h1001, AWADDR[31:16] value that selects slave port S1 (WDT)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
AWID_M/AWADDR_M/AWLEN_M/AWSIZE_M/AWBURST_M/AWVALID_M  input  8/32/4/3/2/1  master write address
AWREADY_M  output  1  master write-address ready
WDATA_M/WSTRB_M/WLAST_M/WVALID_M  input  32/4/1/1  master write data
WREADY_M  output  1  master write-data ready
BID_M/BRESP_M/BVALID_M  output  8/2/1  master write response
BREADY_M  input  1  master response ready
AWID_Sx/AWADDR_Sx/AWLEN_Sx/AWSIZE_Sx/AWBURST_Sx/AWVALID_Sx  output  8/32/4/3/2/1  per slave x in {0,1}, AW forwarded to the slave
AWREADY_Sx  input  1  slave address ready
WDATA_Sx/WSTRB_Sx/WLAST_Sx/WVALID_Sx  output  32/4/1/1  write data forwarded to the slave
WREADY_Sx  input  1  slave data ready
BID_Sx/BRESP_Sx/BVALID_Sx  input  8/2/1  slave response
BREADY_Sx  output  1  slave response ready

Behaviour:
- Widths follow the AXI defines: IDS=8, ADDR=32, LEN=4, SIZE=3, DATA=32, STRB=4.
- Decode is combinational on AWADDR_M[31:16]:
  - == S0_HI selects S0.
  - == S1_HI selects S1.
  - Any other value selects DEF (the internal default slave).
- FSM states are IDLE, DATA and RESP. Reset state is IDLE.
- Registered fields: tgt (2 bits: S0, S1 or DEF) and id (8 bits). Both reset to 0.
- IDLE:
  - AW payload fans out unchanged to both slaves.
  - AWVALID_Sx = AWVALID_M only for the decoded slave; 0 for the other.
  - AWREADY_M = AWREADY of the decoded slave, or 1 when the target is DEF. This is a zero-cycle combinational pass-through.
  - On AWVALID_M && AWREADY_M: latch tgt and AWID_M into id, go to DATA.
  - W is never accepted in IDLE (WREADY_M = 0), including when W arrives in the same cycle as AW.
- DATA:
  - AWREADY_M = 0 and all AWVALID_Sx = 0.
  - W payload fans out to both slaves; WVALID_Sx = WVALID_M only for tgt.
  - WREADY_M = WREADY of tgt, or 1 when tgt is DEF.
  - On a W handshake with WLAST_M = 1, go to RESP.
  - Beats without WLAST_M stay in DATA; LEN is not counted, and WLAST_M is authoritative.
- RESP:
  - For S0/S1: BID_M, BRESP_M and BVALID_M come from tgt; BREADY_Sx = BREADY_M only for tgt.
  - For DEF: BVALID_M = 1, BRESP_M = 2'b11 (DECERR), BID_M = id.
  - On BVALID_M && BREADY_M, go to IDLE. The next AW can be accepted one cycle after the B handshake.
- Outputs when no route is active: BVALID_M = 0, BID_M = 0, BRESP_M = 0. All *VALID_Sx, BREADY_Sx, AWREADY_M and WREADY_M are 0 outside their routed state.
- Reset values: every valid/ready output = 0, BID_M = 0, BRESP_M = 0. Payload outputs are don't-care when not valid; drive them as pass-through.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately, the partially routed burst is abandoned and all valids drop asynchronously.
- The master must hold AW stable while AWVALID_M is high. The decoder does not buffer AW.
- There are no combinational paths from any slave VALID/READY to the same slave's READY/VALID.

Test Plan:
- Single-beat write to 32'h1001_0100, WDATA = 1, BREADY held 1 -> AWVALID_S1 = 1, S0 untouched; WVALID_S1 pulses once with WLAST; BID_M equals AWID_M = 8'h05; BRESP_M = 2'b00; FSM back in IDLE.
- 4-beat burst (AWLEN = 3) to 32'h0001_0000, with WREADY_S0 low for 2 cycles before beat 2 -> exactly 4 W handshakes on S0 in order; RESP entered only after the WLAST beat.
- Write to unmapped 32'h2000_0000, AWID = 8'h3A, 2 beats -> AWREADY_M = 1 in the same cycle; both beats accepted with no slave VALID; BRESP_M = 2'b11, BID_M = 8'h3A.
- AW and W presented in the same cycle -> WREADY_M = 0 in the AW cycle; W accepted the next cycle.
- BREADY_M held low for 5 cycles in RESP -> BVALID_M stays high; a new AWVALID_M is not accepted until one cycle after BREADY_M rises.
- rst pulsed during DATA after 1 of 4 beats -> all valid/ready outputs 0 while rst is high; a fresh write to S1 afterwards completes normally.

Source files
------------

// File: rtl/axi_wr_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : axi_wr_decoder
// Purpose  : Single-outstanding AXI write-channel router. Decodes
//            AWADDR_M[31:16] to slave port S0 (peripheral), S1 (WDT wrapper)
//            or an internal default slave that answers with DECERR.
// Revision : 1.0 - initial release
// ============================================================================
module axi_wr_decoder #(
  parameter logic [15:0] S0_HI = 16'h0001,
  parameter logic [15:0] S1_HI = 16'h1001
) (
  input  logic        clk,
  input  logic        rst,

  // Master write address
  input  logic [7:0]  AWID_M,
  input  logic [31:0] AWADDR_M,
  input  logic [3:0]  AWLEN_M,
  input  logic [2:0]  AWSIZE_M,
  input  logic [1:0]  AWBURST_M,
  input  logic        AWVALID_M,
  output logic        AWREADY_M,
  // Master write data
  input  logic [31:0] WDATA_M,
  input  logic [3:0]  WSTRB_M,
  input  logic        WLAST_M,
  input  logic        WVALID_M,
  output logic        WREADY_M,
  // Master write response
  output logic [7:0]  BID_M,
  output logic [1:0]  BRESP_M,
  output logic        BVALID_M,
  input  logic        BREADY_M,

  // Slave 0 (general peripheral)
  output logic [7:0]  AWID_S0,
  output logic [31:0] AWADDR_S0,
  output logic [3:0]  AWLEN_S0,
  output logic [2:0]  AWSIZE_S0,
  output logic [1:0]  AWBURST_S0,
  output logic        AWVALID_S0,
  input  logic        AWREADY_S0,
  output logic [31:0] WDATA_S0,
  output logic [3:0]  WSTRB_S0,
  output logic        WLAST_S0,
  output logic        WVALID_S0,
  input  logic        WREADY_S0,
  input  logic [7:0]  BID_S0,
  input  logic [1:0]  BRESP_S0,
  input  logic        BVALID_S0,
  output logic        BREADY_S0,

  // Slave 1 (WDT wrapper)
  output logic [7:0]  AWID_S1,
  output logic [31:0] AWADDR_S1,
  output logic [3:0]  AWLEN_S1,
  output logic [2:0]  AWSIZE_S1,
  output logic [1:0]  AWBURST_S1,
  output logic        AWVALID_S1,
  input  logic        AWREADY_S1,
  output logic [31:0] WDATA_S1,
  output logic [3:0]  WSTRB_S1,
  output logic        WLAST_S1,
  output logic        WVALID_S1,
  input  logic        WREADY_S1,
  input  logic [7:0]  BID_S1,
  input  logic [1:0]  BRESP_S1,
  input  logic        BVALID_S1,
  output logic        BREADY_S1
);

  // Transaction phase
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Route target encoding
  localparam logic [1:0] TGT_S0  = 2'd0;
  localparam logic [1:0] TGT_S1  = 2'd1;
  localparam logic [1:0] TGT_DEF = 2'd2;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0] state_q, state_d;
  logic [1:0] tgt_q,   tgt_d;
  logic [7:0] id_q,    id_d;

  logic [1:0] w_dec_tgt;
  logic       w_aw_hs;
  logic       w_w_last_hs;
  logic       w_b_hs;

  // Payloads are broadcast; only the valids are steered.
  assign AWID_S0    = AWID_M;
  assign AWADDR_S0  = AWADDR_M;
  assign AWLEN_S0   = AWLEN_M;
  assign AWSIZE_S0  = AWSIZE_M;
  assign AWBURST_S0 = AWBURST_M;
  assign WDATA_S0   = WDATA_M;
  assign WSTRB_S0   = WSTRB_M;
  assign WLAST_S0   = WLAST_M;

  assign AWID_S1    = AWID_M;
  assign AWADDR_S1  = AWADDR_M;
  assign AWLEN_S1   = AWLEN_M;
  assign AWSIZE_S1  = AWSIZE_M;
  assign AWBURST_S1 = AWBURST_M;
  assign WDATA_S1   = WDATA_M;
  assign WSTRB_S1   = WSTRB_M;
  assign WLAST_S1   = WLAST_M;

  // Address decode on the upper half-word of AWADDR
  always_comb begin
    if (AWADDR_M[31:16] == S0_HI) begin
      w_dec_tgt = TGT_S0;
    end else if (AWADDR_M[31:16] == S1_HI) begin
      w_dec_tgt = TGT_S1;
    end else begin
      w_dec_tgt = TGT_DEF;
    end
  end

  // Channel steering: each channel is only open in its own phase. While rst
  // is high every valid/ready is forced low so nothing leaks through the
  // combinational IDLE path.
  always_comb begin
    AWVALID_S0 = 1'b0;
    AWVALID_S1 = 1'b0;
    AWREADY_M  = 1'b0;
    WVALID_S0  = 1'b0;
    WVALID_S1  = 1'b0;
    WREADY_M   = 1'b0;
    BVALID_M   = 1'b0;
    BID_M      = 8'h00;
    BRESP_M    = 2'b00;
    BREADY_S0  = 1'b0;
    BREADY_S1  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        case (w_dec_tgt)
          TGT_S0: begin
            AWVALID_S0 = AWVALID_M;
            AWREADY_M  = AWREADY_S0;
          end
          TGT_S1: begin
            AWVALID_S1 = AWVALID_M;
            AWREADY_M  = AWREADY_S1;
          end
          default: begin
            AWREADY_M  = 1'b1;
          end
        endcase
      end
      ST_DATA: begin
        case (tgt_q)
          TGT_S0: begin
            WVALID_S0 = WVALID_M;
            WREADY_M  = WREADY_S0;
          end
          TGT_S1: begin
            WVALID_S1 = WVALID_M;
            WREADY_M  = WREADY_S1;
          end
          default: begin
            WREADY_M  = 1'b1;
          end
        endcase
      end
      ST_RESP: begin
        case (tgt_q)
          TGT_S0: begin
            BVALID_M  = BVALID_S0;
            BID_M     = BID_S0;
            BRESP_M   = BRESP_S0;
            BREADY_S0 = BREADY_M;
          end
          TGT_S1: begin
            BVALID_M  = BVALID_S1;
            BID_M     = BID_S1;
            BRESP_M   = BRESP_S1;
            BREADY_S1 = BREADY_M;
          end
          default: begin
            BVALID_M  = 1'b1;
            BID_M     = id_q;
            BRESP_M   = RESP_DECERR;
          end
        endcase
      end
      default: begin
      end
    endcase

    if (rst) begin
      AWVALID_S0 = 1'b0;
      AWVALID_S1 = 1'b0;
      AWREADY_M  = 1'b0;
      WVALID_S0  = 1'b0;
      WVALID_S1  = 1'b0;
      WREADY_M   = 1'b0;
      BVALID_M   = 1'b0;
      BID_M      = 8'h00;
      BRESP_M    = 2'b00;
      BREADY_S0  = 1'b0;
      BREADY_S1  = 1'b0;
    end
  end

  assign w_aw_hs     = AWVALID_M & AWREADY_M;
  assign w_w_last_hs = WVALID_M & WREADY_M & WLAST_M;
  assign w_b_hs      = BVALID_M & BREADY_M;

  // Phase sequencing; WLAST alone closes the data phase (AWLEN is not counted)
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (w_aw_hs) begin
          state_d = ST_DATA;
          tgt_d   = w_dec_tgt;
          id_d    = AWID_M;
        end
      end
      ST_DATA: begin
        if (w_w_last_hs) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_b_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Phase, route and ID registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tgt_q   <= 2'd0;
      id_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      id_q    <= id_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_axi_wr_decoder
// Purpose  : Self-checking bench for axi_wr_decoder (directed scenarios plus
//            randomized transactions against an address-map model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wr_decoder;

  localparam logic [15:0] S0_HI = 16'h0001;
  localparam logic [15:0] S1_HI = 16'h1001;

  logic        clk;
  logic        rst;
  logic [7:0]  AWID_M;
  logic [31:0] AWADDR_M;
  logic [3:0]  AWLEN_M;
  logic [2:0]  AWSIZE_M;
  logic [1:0]  AWBURST_M;
  logic        AWVALID_M;
  logic        AWREADY_M;
  logic [31:0] WDATA_M;
  logic [3:0]  WSTRB_M;
  logic        WLAST_M;
  logic        WVALID_M;
  logic        WREADY_M;
  logic [7:0]  BID_M;
  logic [1:0]  BRESP_M;
  logic        BVALID_M;
  logic        BREADY_M;

  logic [7:0]  AWID_S0, AWID_S1;
  logic [31:0] AWADDR_S0, AWADDR_S1;
  logic [3:0]  AWLEN_S0, AWLEN_S1;
  logic [2:0]  AWSIZE_S0, AWSIZE_S1;
  logic [1:0]  AWBURST_S0, AWBURST_S1;
  logic        AWVALID_S0, AWVALID_S1;
  logic        AWREADY_S0, AWREADY_S1;
  logic [31:0] WDATA_S0, WDATA_S1;
  logic [3:0]  WSTRB_S0, WSTRB_S1;
  logic        WLAST_S0, WLAST_S1;
  logic        WVALID_S0, WVALID_S1;
  logic        WREADY_S0, WREADY_S1;
  logic [7:0]  BID_S0, BID_S1;
  logic [1:0]  BRESP_S0, BRESP_S1;
  logic        BVALID_S0, BVALID_S1;
  logic        BREADY_S0, BREADY_S1;

  int total = 0;
  int bad   = 0;

  // Observation logs filled once per cycle just before the active edge
  logic [31:0] s0_aw_q[$];
  logic [31:0] s1_aw_q[$];
  logic [32:0] s0_w_q[$];
  logic [32:0] s1_w_q[$];
  int s0_awv, s1_awv, s0_wv, s1_wv, s0_brdy, s1_brdy, m_w_cnt;

  logic [8:0] vld_vec;
  assign vld_vec = {AWVALID_S0, AWVALID_S1, WVALID_S0, WVALID_S1, BREADY_S0,
                    BREADY_S1, AWREADY_M, WREADY_M, BVALID_M};

  axi_wr_decoder #(.S0_HI(S0_HI), .S1_HI(S1_HI)) u_dut (
    .clk(clk), .rst(rst),
    .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
    .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
    .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
    .WREADY_M(WREADY_M), .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M),
    .BREADY_M(BREADY_M),
    .AWID_S0(AWID_S0), .AWADDR_S0(AWADDR_S0), .AWLEN_S0(AWLEN_S0), .AWSIZE_S0(AWSIZE_S0),
    .AWBURST_S0(AWBURST_S0), .AWVALID_S0(AWVALID_S0), .AWREADY_S0(AWREADY_S0),
    .WDATA_S0(WDATA_S0), .WSTRB_S0(WSTRB_S0), .WLAST_S0(WLAST_S0), .WVALID_S0(WVALID_S0),
    .WREADY_S0(WREADY_S0), .BID_S0(BID_S0), .BRESP_S0(BRESP_S0), .BVALID_S0(BVALID_S0),
    .BREADY_S0(BREADY_S0),
    .AWID_S1(AWID_S1), .AWADDR_S1(AWADDR_S1), .AWLEN_S1(AWLEN_S1), .AWSIZE_S1(AWSIZE_S1),
    .AWBURST_S1(AWBURST_S1), .AWVALID_S1(AWVALID_S1), .AWREADY_S1(AWREADY_S1),
    .WDATA_S1(WDATA_S1), .WSTRB_S1(WSTRB_S1), .WLAST_S1(WLAST_S1), .WVALID_S1(WVALID_S1),
    .WREADY_S1(WREADY_S1), .BID_S1(BID_S1), .BRESP_S1(BRESP_S1), .BVALID_S1(BVALID_S1),
    .BREADY_S1(BREADY_S1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address map model: 0 = S0, 1 = S1, 2 = default slave
  function automatic int model_tgt(input logic [31:0] addr);
    if (addr[31:16] == S0_HI) return 0;
    if (addr[31:16] == S1_HI) return 1;
    return 2;
  endfunction

  task automatic clear_logs();
    s0_aw_q.delete(); s1_aw_q.delete(); s0_w_q.delete(); s1_w_q.delete();
    s0_awv = 0; s1_awv = 0; s0_wv = 0; s1_wv = 0; s0_brdy = 0; s1_brdy = 0; m_w_cnt = 0;
  endtask

  // Record what will happen at the coming rising edge, then move to the next falling edge
  task automatic tick();
    #1;
    if (AWVALID_S0) s0_awv++;
    if (AWVALID_S1) s1_awv++;
    if (WVALID_S0) s0_wv++;
    if (WVALID_S1) s1_wv++;
    if (BREADY_S0) s0_brdy++;
    if (BREADY_S1) s1_brdy++;
    if (AWVALID_S0 && AWREADY_S0) s0_aw_q.push_back(AWADDR_S0);
    if (AWVALID_S1 && AWREADY_S1) s1_aw_q.push_back(AWADDR_S1);
    if (WVALID_S0 && WREADY_S0) s0_w_q.push_back({WLAST_S0, WDATA_S0});
    if (WVALID_S1 && WREADY_S1) s1_w_q.push_back({WLAST_S1, WDATA_S1});
    if (WVALID_M && WREADY_M) m_w_cnt++;
    @(negedge clk);
  endtask

  task automatic drive_aw(input logic [31:0] addr, input logic [7:0] id, input logic [3:0] len,
                          input int stall, output logic ok);
    AWADDR_M = addr; AWID_M = id; AWLEN_M = len; AWSIZE_M = 3'd2; AWBURST_M = 2'b01;
    AWVALID_M = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      AWREADY_S0 = (c >= stall); AWREADY_S1 = (c >= stall);
      #1;
      if (AWREADY_M) ok = 1'b1;
      tick();
    end
    AWVALID_M = 1'b0; AWREADY_S0 = 1'b1; AWREADY_S1 = 1'b1;
  endtask

  task automatic drive_w(input logic [31:0] data, input logic last, input int stall,
                         output logic ok);
    WDATA_M = data; WSTRB_M = 4'hF; WLAST_M = last; WVALID_M = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 30 && !ok; c++) begin
      WREADY_S0 = (c >= stall); WREADY_S1 = (c >= stall);
      #1;
      if (WREADY_M) ok = 1'b1;
      tick();
    end
    WVALID_M = 1'b0; WLAST_M = 1'b0; WREADY_S0 = 1'b1; WREADY_S1 = 1'b1;
  endtask

  // Slave tgt (0/1) raises its response; tgt 2 means no slave responds
  task automatic drive_b(input int tgt, input logic [1:0] resp, input logic [7:0] bid,
                         input int delay, output logic [1:0] got_resp,
                         output logic [7:0] got_id, output logic ok);
    got_resp = 2'bxx; got_id = 8'hxx; ok = 1'b0;
    BID_S0 = ~bid; BRESP_S0 = ~resp; BID_S1 = ~bid; BRESP_S1 = ~resp;
    if (tgt == 0) begin BVALID_S0 = 1'b1; BID_S0 = bid; BRESP_S0 = resp; end
    if (tgt == 1) begin BVALID_S1 = 1'b1; BID_S1 = bid; BRESP_S1 = resp; end
    for (int c = 0; c < 40 && !ok; c++) begin
      BREADY_M = (c >= delay);
      #1;
      if (BVALID_M && BREADY_M) begin
        got_resp = BRESP_M; got_id = BID_M; ok = 1'b1;
      end
      tick();
    end
    BREADY_M = 1'b0; BVALID_S0 = 1'b0; BVALID_S1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    AWADDR_M = 32'h1001_0000; AWVALID_M = 1'b1; WVALID_M = 1'b1; WLAST_M = 1'b1;
    BREADY_M = 1'b1; BVALID_S0 = 1'b1; BVALID_S1 = 1'b1;
    #1;
    total++;
    if (vld_vec !== 9'b0) begin bad++; $display("FAIL reset_valids: got %b want 000000000", vld_vec); end
    total++;
    if ({BID_M, BRESP_M} !== 10'b0) begin bad++; $display("FAIL reset_bfields: got %h want 000", {BID_M, BRESP_M}); end
    tick();
    AWVALID_M = 1'b0; WVALID_M = 1'b0; WLAST_M = 1'b0; BREADY_M = 1'b0;
    BVALID_S0 = 1'b0; BVALID_S1 = 1'b0; rst = 1'b0;
    AWADDR_M = 32'h2000_0000;
    #1;
    total++;
    if (AWREADY_M !== 1'b1) begin bad++; $display("FAIL idle_def_awready: got %b want 1", AWREADY_M); end
    AWADDR_M = 32'h0001_0000; AWREADY_S0 = 1'b0;
    #1;
    total++;
    if (AWREADY_M !== 1'b0) begin bad++; $display("FAIL idle_s0_awready_low: got %b want 0", AWREADY_M); end
    AWREADY_S0 = 1'b1;
    #1;
    total++;
    if (AWREADY_M !== 1'b1) begin bad++; $display("FAIL idle_s0_awready_high: got %b want 1", AWREADY_M); end
    tick();
  endtask

  task automatic test_single_s1();
    logic ok; logic [1:0] r; logic [7:0] b;
    clear_logs();
    drive_aw(32'h1001_0100, 8'h05, 4'd0, 0, ok);
    total++;
    if (ok !== 1'b1 || s1_aw_q.size() != 1 || s0_awv != 0)
      begin bad++; $display("FAIL single_aw: got ok=%b s1_aw=%0d s0_awv=%0d want 1/1/0", ok, s1_aw_q.size(), s0_awv); end
    total++;
    if (s1_aw_q.size() == 1 && s1_aw_q[0] !== 32'h1001_0100)
      begin bad++; $display("FAIL single_aw_addr: got %h want 10010100", s1_aw_q[0]); end
    drive_w(32'h1, 1'b1, 0, ok);
    total++;
    if (ok !== 1'b1 || s1_w_q.size() != 1 || s0_wv != 0)
      begin bad++; $display("FAIL single_w: got ok=%b s1_w=%0d s0_wv=%0d want 1/1/0", ok, s1_w_q.size(), s0_wv); end
    total++;
    if (s1_w_q.size() == 1 && s1_w_q[0] !== {1'b1, 32'h1})
      begin bad++; $display("FAIL single_w_beat: got %h want 100000001", s1_w_q[0]); end
    drive_b(1, 2'b00, 8'h05, 0, r, b, ok);
    total++;
    if (ok !== 1'b1 || b !== 8'h05 || r !== 2'b00)
      begin bad++; $display("FAIL single_b: got ok=%b id=%h resp=%b want 1/05/00", ok, b, r); end
    AWADDR_M = 32'h2000_0000;
    #1;
    total++;
    if (AWREADY_M !== 1'b1) begin bad++; $display("FAIL single_back_idle: got %b want 1", AWREADY_M); end
    tick();
  endtask

  task automatic test_burst_s0();
    logic ok, all_ok; logic [1:0] r; logic [7:0] b; logic [31:0] d[4];
    clear_logs();
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    drive_aw(32'h0001_0000, 8'h11, 4'd3, 0, all_ok);
    for (int i = 0; i < 3; i++) begin
      drive_w(d[i], 1'b0, (i == 1) ? 2 : 0, ok);
      all_ok = all_ok & ok;
    end
    BREADY_M = 1'b1;
    #1;
    total++;
    if (WREADY_M !== 1'b1 || BREADY_S0 !== 1'b0)
      begin bad++; $display("FAIL burst_still_data: got wready=%b bready_s0=%b want 1/0", WREADY_M, BREADY_S0); end
    BREADY_M = 1'b0;
    drive_w(d[3], 1'b1, 0, ok);
    all_ok = all_ok & ok;
    BREADY_M = 1'b1;
    #1;
    total++;
    if (WREADY_M !== 1'b0 || BREADY_S0 !== 1'b1)
      begin bad++; $display("FAIL burst_resp_after_last: got wready=%b bready_s0=%b want 0/1", WREADY_M, BREADY_S0); end
    BREADY_M = 1'b0;
    total++;
    if (all_ok !== 1'b1 || s0_w_q.size() != 4 || s1_wv != 0)
      begin bad++; $display("FAIL burst_count: got ok=%b s0_w=%0d s1_wv=%0d want 1/4/0", all_ok, s0_w_q.size(), s1_wv); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (s0_w_q[i] !== {(i == 3), d[i]})
          begin bad++; $display("FAIL burst_beat%0d: got %h want %h", i, s0_w_q[i], {(i == 3), d[i]}); end
      end
    end
    drive_b(0, 2'b00, 8'h11, 0, r, b, ok);
    total++;
    if (ok !== 1'b1 || b !== 8'h11 || r !== 2'b00)
      begin bad++; $display("FAIL burst_b: got ok=%b id=%h resp=%b want 1/11/00", ok, b, r); end
  endtask

  task automatic test_unmapped();
    logic ok, all_ok; logic [1:0] r; logic [7:0] b;
    clear_logs();
    AWADDR_M = 32'h2000_0000; AWID_M = 8'h3A; AWLEN_M = 4'd1; AWVALID_M = 1'b1;
    AWREADY_S0 = 1'b0; AWREADY_S1 = 1'b0;
    #1;
    total++;
    if (AWREADY_M !== 1'b1) begin bad++; $display("FAIL unmapped_aw_same_cycle: got %b want 1", AWREADY_M); end
    tick();
    AWVALID_M = 1'b0; AWREADY_S0 = 1'b1; AWREADY_S1 = 1'b1;
    drive_w($urandom, 1'b0, 1, all_ok);
    drive_w($urandom, 1'b1, 1, ok);
    all_ok = all_ok & ok;
    total++;
    if (all_ok !== 1'b1 || m_w_cnt != 2 || (s0_wv + s1_wv + s0_awv + s1_awv) != 0)
      begin bad++; $display("FAIL unmapped_w: got ok=%b beats=%0d slave_valids=%0d want 1/2/0", all_ok, m_w_cnt, s0_wv + s1_wv + s0_awv + s1_awv); end
    drive_b(2, 2'b00, 8'h00, 0, r, b, ok);
    total++;
    if (ok !== 1'b1 || r !== 2'b11 || b !== 8'h3A || (s0_brdy + s1_brdy) != 0)
      begin bad++; $display("FAIL unmapped_b: got ok=%b resp=%b id=%h brdy=%0d want 1/11/3a/0", ok, r, b, s0_brdy + s1_brdy); end
  endtask

  task automatic test_aw_w_same_cycle();
    logic ok; logic [1:0] r; logic [7:0] b;
    clear_logs();
    AWADDR_M = 32'h0001_0040; AWID_M = 8'h21; AWLEN_M = 4'd0; AWVALID_M = 1'b1;
    WDATA_M = 32'hCAFE_0001; WSTRB_M = 4'hF; WLAST_M = 1'b1; WVALID_M = 1'b1;
    #1;
    total++;
    if (WREADY_M !== 1'b0 || AWREADY_M !== 1'b1)
      begin bad++; $display("FAIL same_cycle_aw: got wready=%b awready=%b want 0/1", WREADY_M, AWREADY_M); end
    tick();
    AWVALID_M = 1'b0;
    #1;
    total++;
    if (WREADY_M !== 1'b1) begin bad++; $display("FAIL same_cycle_w_next: got %b want 1", WREADY_M); end
    tick();
    WVALID_M = 1'b0; WLAST_M = 1'b0;
    total++;
    if (s0_w_q.size() != 1 || s0_w_q[0] !== {1'b1, 32'hCAFE_0001})
      begin bad++; $display("FAIL same_cycle_beats: got n=%0d want 1 beat 1cafe0001", s0_w_q.size()); end
    drive_b(0, 2'b00, 8'h21, 0, r, b, ok);
    total++;
    if (ok !== 1'b1 || b !== 8'h21) begin bad++; $display("FAIL same_cycle_b: got ok=%b id=%h want 1/21", ok, b); end
  endtask

  task automatic test_bready_stall();
    logic ok; logic [1:0] r; logic [7:0] b;
    clear_logs();
    drive_aw(32'h1001_0008, 8'h77, 4'd0, 0, ok);
    drive_w($urandom, 1'b1, 0, ok);
    BVALID_S1 = 1'b1; BRESP_S1 = 2'b01; BID_S1 = 8'h77; BREADY_M = 1'b0;
    AWADDR_M = 32'h0001_0004; AWID_M = 8'h78; AWLEN_M = 4'd0; AWVALID_M = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (BVALID_M !== 1'b1 || AWREADY_M !== 1'b0)
        begin bad++; $display("FAIL stall_hold%0d: got bvalid=%b awready=%b want 1/0", c, BVALID_M, AWREADY_M); end
      tick();
    end
    BREADY_M = 1'b1;
    #1;
    total++;
    if (BVALID_M !== 1'b1 || BRESP_M !== 2'b01 || BID_M !== 8'h77 || AWREADY_M !== 1'b0)
      begin bad++; $display("FAIL stall_release: got bvalid=%b resp=%b id=%h awready=%b want 1/01/77/0", BVALID_M, BRESP_M, BID_M, AWREADY_M); end
    tick();
    BVALID_S1 = 1'b0; BREADY_M = 1'b0;
    #1;
    total++;
    if (AWREADY_M !== 1'b1) begin bad++; $display("FAIL stall_next_aw: got %b want 1", AWREADY_M); end
    tick();
    AWVALID_M = 1'b0;
    total++;
    if (s0_aw_q.size() != 1) begin bad++; $display("FAIL stall_next_aw_count: got %0d want 1", s0_aw_q.size()); end
    drive_w($urandom, 1'b1, 0, ok);
    drive_b(0, 2'b00, 8'h78, 0, r, b, ok);
    total++;
    if (ok !== 1'b1 || b !== 8'h78) begin bad++; $display("FAIL stall_second_b: got ok=%b id=%h want 1/78", ok, b); end
  endtask

  task automatic test_reset_mid();
    logic ok, all_ok; logic [1:0] r; logic [7:0] b; logic [31:0] d;
    clear_logs();
    drive_aw(32'h0001_0100, 8'h44, 4'd3, 0, ok);
    drive_w($urandom, 1'b0, 0, ok);
    WDATA_M = $urandom; WLAST_M = 1'b0; WVALID_M = 1'b1; rst = 1'b1;
    #1;
    total++;
    if (vld_vec !== 9'b0) begin bad++; $display("FAIL rst_mid_valids: got %b want 000000000", vld_vec); end
    tick();
    rst = 1'b0; WVALID_M = 1'b0;
    total++;
    if (s0_w_q.size() != 1) begin bad++; $display("FAIL rst_mid_no_extra: got %0d want 1", s0_w_q.size()); end
    clear_logs();
    d = $urandom;
    drive_aw(32'h1001_0200, 8'h45, 4'd0, 0, all_ok);
    drive_w(d, 1'b1, 0, ok);
    all_ok = all_ok & ok;
    drive_b(1, 2'b00, 8'h45, 0, r, b, ok);
    all_ok = all_ok & ok;
    total++;
    if (all_ok !== 1'b1 || s1_w_q.size() != 1 || s0_wv != 0 || b !== 8'h45 || r !== 2'b00)
      begin bad++; $display("FAIL rst_mid_fresh: got ok=%b s1_w=%0d s0_wv=%0d id=%h resp=%b want 1/1/0/45/00", all_ok, s1_w_q.size(), s0_wv, b, r); end
    else begin
      total++;
      if (s1_w_q[0] !== {1'b1, d}) begin bad++; $display("FAIL rst_mid_fresh_data: got %h want %h", s1_w_q[0], {1'b1, d}); end
    end
  endtask

  task automatic test_random();
    logic ok, all_ok, werr; logic [1:0] r, resp_s, exp_resp; logic [7:0] b, id, bid_s, exp_bid;
    logic [15:0] hi; logic [31:0] addr; int nbeats, tgt, kind;
    logic [32:0] exp_q[$]; logic [32:0] got_q[$];
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) hi = S0_HI;
      else if (kind == 1) hi = S1_HI;
      else begin
        hi = $urandom;
        while (hi == S0_HI || hi == S1_HI) hi = $urandom;
      end
      addr = {hi, 16'($urandom)};
      id = $urandom; bid_s = $urandom; resp_s = 2'($urandom_range(0, 2));
      nbeats = $urandom_range(1, 4);
      tgt = model_tgt(addr);
      exp_resp = (tgt == 2) ? 2'b11 : resp_s;
      exp_bid  = (tgt == 2) ? id : bid_s;
      clear_logs(); exp_q.delete(); got_q.delete();
      drive_aw(addr, id, 4'(nbeats - 1), $urandom_range(0, 2), all_ok);
      for (int i = 0; i < nbeats; i++) begin
        exp_q.push_back({(i == nbeats - 1), 32'($urandom)});
        drive_w(exp_q[i][31:0], exp_q[i][32], $urandom_range(0, 2), ok);
        all_ok = all_ok & ok;
      end
      drive_b(tgt, resp_s, bid_s, $urandom_range(0, 3), r, b, ok);
      all_ok = all_ok & ok;
      total++;
      if (all_ok !== 1'b1 || r !== exp_resp || b !== exp_bid)
        begin bad++; $display("FAIL rand%0d_b addr=%h: got ok=%b resp=%b id=%h want 1/%b/%h", n, addr, all_ok, r, b, exp_resp, exp_bid); end
      if (tgt == 0) got_q = s0_w_q;
      if (tgt == 1) got_q = s1_w_q;
      werr = (tgt == 2) ? (m_w_cnt != nbeats) : (got_q.size() != nbeats);
      if (tgt != 2 && !werr)
        for (int i = 0; i < nbeats; i++) if (got_q[i] !== exp_q[i]) werr = 1'b1;
      if (tgt != 0 && (s0_wv != 0 || s0_awv != 0 || s0_brdy != 0)) werr = 1'b1;
      if (tgt != 1 && (s1_wv != 0 || s1_awv != 0 || s1_brdy != 0)) werr = 1'b1;
      if (tgt == 0 && (s0_aw_q.size() != 1 || s0_aw_q[0] !== addr)) werr = 1'b1;
      if (tgt == 1 && (s1_aw_q.size() != 1 || s1_aw_q[0] !== addr)) werr = 1'b1;
      total++;
      if (werr !== 1'b0)
        begin bad++; $display("FAIL rand%0d_route addr=%h tgt=%0d: got beats s0=%0d s1=%0d m=%0d want %0d on tgt only", n, addr, tgt, s0_w_q.size(), s1_w_q.size(), m_w_cnt, nbeats); end
    end
  endtask

  initial begin
    rst = 1'b1;
    AWID_M = 8'h00; AWADDR_M = 32'h0; AWLEN_M = 4'd0; AWSIZE_M = 3'd2; AWBURST_M = 2'b01;
    AWVALID_M = 1'b0; WDATA_M = 32'h0; WSTRB_M = 4'hF; WLAST_M = 1'b0; WVALID_M = 1'b0;
    BREADY_M = 1'b0;
    AWREADY_S0 = 1'b1; AWREADY_S1 = 1'b1; WREADY_S0 = 1'b1; WREADY_S1 = 1'b1;
    BID_S0 = 8'h00; BID_S1 = 8'h00; BRESP_S0 = 2'b00; BRESP_S1 = 2'b00;
    BVALID_S0 = 1'b0; BVALID_S1 = 1'b0;
    clear_logs();
    @(negedge clk);
    test_reset();
    test_single_s1();
    test_burst_s0();
    test_unmapped();
    test_aw_w_same_cycle();
    test_bready_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
